// File: rtl/divide_param.sv
`default_nettype none
// ============================================================================
// divide_param : multi-cycle restoring divider, DD_W/DV_W bits, signed/unsigned
// Revision     : 1.0
// ============================================================================
module divide_param #(
  parameter int DV_W = 16,
  parameter int DD_W = 2*DV_W
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [DD_W-1:0] dividend,
  input  logic [DV_W-1:0] divisor,
  output logic [DV_W-1:0] quotient,
  output logic [DV_W-1:0] remainder,
  output logic            done,
  output logic            busy,
  output logic            div_by_zero,
  output logic            overflow,
  output logic [2:0]      est_presente
);

  localparam int CW = $clog2(DV_W);
  localparam logic [DV_W-1:0] c_half    = {1'b1, {(DV_W-1){1'b0}}};
  localparam logic [DV_W-1:0] c_max_pos = {1'b0, {(DV_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_ABS   = 3'b001,
    S_CHECK = 3'b010,
    S_ITER  = 3'b011,
    S_FIX   = 3'b100,
    S_DONE  = 3'b101
  } state_t;

  state_t          r_state;
  logic            r_sm;
  logic            r_neg_dd;
  logic            r_neg_dv;
  logic [DD_W-1:0] r_dd;
  logic [DV_W-1:0] r_dv;
  logic [DV_W:0]   r_p;
  logic [DV_W-1:0] r_a;
  logic [CW-1:0]   r_cnt;

  logic [DD_W-1:0] w_dd_mag;
  logic [DV_W-1:0] w_dv_mag;
  logic [DV_W:0]   w_shift;
  logic [DV_W+1:0] w_trial;
  logic [DV_W-1:0] w_q_neg;
  logic [DV_W-1:0] w_r_neg;
  logic            w_q_sign;
  logic            w_sovf;

  assign w_dd_mag = (r_sm && r_dd[DD_W-1]) ? -r_dd : r_dd;
  assign w_dv_mag = (r_sm && r_dv[DV_W-1]) ? -r_dv : r_dv;

  // r_p holds the partial remainder in ITER; the extra bit absorbs the shift-out
  assign w_shift  = {r_p[DV_W-1:0], r_a[DV_W-1]};
  assign w_trial  = {1'b0, w_shift} - {2'b00, r_dv};

  assign w_q_neg  = -r_a;
  assign w_r_neg  = -r_p[DV_W-1:0];
  assign w_q_sign = r_neg_dd ^ r_neg_dv;
  assign w_sovf   = r_sm & (w_q_sign ? (r_a > c_half) : (r_a > c_max_pos));

  assign est_presente = r_state;

  always_ff @(negedge reloj) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sm        <= 1'b0;
      r_neg_dd    <= 1'b0;
      r_neg_dv    <= 1'b0;
      r_dd        <= '0;
      r_dv        <= '0;
      r_p         <= '0;
      r_a         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dd        <= dividend;
            r_dv        <= divisor;
            r_sm        <= signed_mode;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            r_state     <= S_ABS;
          end
        end
        S_ABS: begin
          r_neg_dd <= r_sm & r_dd[DD_W-1];
          r_neg_dv <= r_sm & r_dv[DV_W-1];
          r_p      <= {1'b0, w_dd_mag[DD_W-1:DV_W]};
          r_a      <= w_dd_mag[DV_W-1:0];
          r_dv     <= w_dv_mag;
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (r_dv == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= r_dd[DV_W-1:0];
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_p >= {1'b0, r_dv}) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt   <= CW'(DV_W-1);
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (!w_trial[DV_W+1]) begin
            r_p <= w_trial[DV_W:0];
            r_a <= {r_a[DV_W-2:0], 1'b1};
          end else begin
            r_p <= w_shift;
            r_a <= {r_a[DV_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_sovf) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            quotient  <= w_q_sign ? w_q_neg : r_a;
            remainder <= r_neg_dd ? w_r_neg : r_p[DV_W-1:0];
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divide_param.sv
`default_nettype none
// ============================================================================
// tb_divide_param : directed/random bench for divide_param (DV_W = 16)
// Revision        : 1.0
// ============================================================================
module tb_divide_param;

  logic        reloj;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;
  logic [2:0]  est_presente;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam int NONE = 100;

  divide_param #(.DV_W(16)) dut (
    .reloj        (reloj),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .done         (done),
    .busy         (busy),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow),
    .est_presente (est_presente)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended operands
  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv, input logic sm);
    exp_t   e;
    longint a, b, ma, mb, q, r;
    e = '{q: 16'h0, r: 16'h0, dbz: 1'b0, ovf: 1'b0, lat: 19};
    if (sm) begin
      a = $signed(dd);
      b = $signed(dv);
    end else begin
      a = dd;
      b = dv;
    end
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    if (mb == 0) begin
      e.dbz = 1'b1; e.q = 16'hFFFF; e.r = dd[15:0]; e.lat = 2;
    end else if ((ma >> 16) >= mb) begin
      e.ovf = 1'b1; e.lat = 2;
    end else begin
      q = a / b;
      r = a % b;
      if (sm && (q > 32767 || q < -32768)) begin
        e.ovf = 1'b1;
      end else begin
        e.q = q[15:0];
        e.r = r[15:0];
      end
    end
    return e;
  endfunction

  // Called on a posedge; returns on the posedge following the accepting edge
  task automatic launch(input logic [31:0] dd, input logic [15:0] dv, input logic sm,
                        input bit hold);
    dividend    = dd;
    divisor     = dv;
    signed_mode = sm;
    start       = 1'b1;
    sb.push_back(model(dd, dv, sm));
    @(posedge reloj);
    if (!hold) start = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  // Entered at the sample after edge 0; poke pulses start on edge poke+1
  task automatic wait_done(input int poke);
    exp_t e;
    int   k;
    logic busy_ok;
    e       = sb.pop_front();
    k       = 0;
    busy_ok = busy;
    while (done !== 1'b1 && k < 40) begin
      if (k == 1) check("est_check", est_presente, 3'd2);
      if (k == poke) begin
        start       = 1'b1;
        dividend    = $urandom;
        divisor     = 16'($urandom);
        signed_mode = ~signed_mode;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      @(posedge reloj);
      k++;
      busy_ok = busy_ok & busy;
    end
    check("latency", k, e.lat);
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", div_by_zero, e.dbz);
    check("overflow", overflow, e.ovf);
    check("busy_during_op", busy_ok, 1'b1);
    check("est_done", est_presente, 3'd5);
    @(posedge reloj);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    int   k;
    logic seen_done;
    logic [31:0] dd;
    logic [15:0] dv;

    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge reloj);
    check("rst_est", est_presente, 3'd0);
    check("rst_q", quotient, 16'h0);
    check("rst_r", remainder, 16'h0);
    check("rst_flags", {done, busy, div_by_zero, overflow}, 4'b0000);
    reset = 1'b1;
    @(posedge reloj);

    launch(32'd100000, 16'd7, 1'b0, 1'b0);     wait_done(NONE);
    launch(32'hFFFFFF9C, 16'd7, 1'b1, 1'b0);   wait_done(NONE);
    launch(32'd100, 16'hFFF9, 1'b1, 1'b0);     wait_done(NONE);
    launch(32'h12345678, 16'd0, 1'b0, 1'b0);   wait_done(NONE);
    launch(32'h00010000, 16'd1, 1'b0, 1'b0);   wait_done(NONE);
    launch(32'h00008000, 16'd1, 1'b1, 1'b0);   wait_done(NONE);
    launch(32'hFFFF8000, 16'd1, 1'b1, 1'b0);   wait_done(NONE);
    launch(32'h80000000, 16'h8000, 1'b1, 1'b0); wait_done(NONE);
    launch(32'hFFFF0001, 16'hFFFF, 1'b0, 1'b0); wait_done(NONE);

    for (int i = 0; i < 8; i++) begin
      dd = $urandom;
      if (i % 2 == 1) dd = dd >>> 12;
      if (i % 4 == 3) dd = -dd;
      dv = 16'($urandom_range(1, 65535));
      launch(dd, dv, (i % 3) != 0, 1'b0);
      wait_done(NONE);
    end

    // start pulse at edge 5 of a running operation must be ignored
    launch(32'd987654, 16'd321, 1'b0, 1'b0);
    wait_done(4);

    // reset on edge 8 abandons the operation
    launch(32'd5555555, 16'd999, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (7) @(posedge reloj);
    reset = 1'b0;
    @(posedge reloj);
    check("midrst_est", est_presente, 3'd0);
    check("midrst_q", quotient, 16'h0);
    check("midrst_r", remainder, 16'h0);
    check("midrst_flags", {done, busy, div_by_zero, overflow}, 4'b0000);
    reset = 1'b1;
    seen_done = 1'b0;
    for (k = 0; k < 25; k++) begin
      @(posedge reloj);
      seen_done = seen_done | done | busy;
    end
    check("midrst_no_done", seen_done, 1'b0);

    // start held high across two operations
    dividend = 32'd1000; divisor = 16'd3; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(32'd1000, 16'd3, 1'b0));
    @(posedge reloj);
    dividend = 32'hFFFFFC18; divisor = 16'd9; signed_mode = 1'b1;
    sb.push_back(model(32'hFFFFFC18, 16'd9, 1'b1));
    wait_done(NONE);
    @(posedge reloj);
    start = 1'b0;
    dividend = $urandom;
    wait_done(NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
